// File: rtl/image_fetcher_pkg.sv
// image_fetcher_pkg: shared state encoding, raster defaults and address width for the image fetcher.
package image_fetcher_pkg;
    typedef enum logic {WAIT_SYNC, RUN} state_t;
    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;
    localparam int ADDR_W = 17;
endpackage

// File: rtl/image_fetcher_pixel_queue.sv
// pixel_queue: two-entry pixel FIFO with simultaneous push/pop; push when full is dropped.
module pixel_queue #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr, do_push, do_pop;
    always_comb begin
        empty    = count == 2'd0;
        full     = count == 2'd2;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ do_push;
            rd_ptr <= rd_ptr ^ do_pop;
            count  <= count + 2'(do_push) - 2'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/image_fetcher.sv
// image_fetcher: fetches framebuffer pixels two positions ahead of the raster and presents them as gray RGB.
module image_fetcher
    import image_fetcher_pkg::*;
#(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int MEM_LAT = 1,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic              FPGA_Clock,
    input  logic              reset,
    input  logic [9:0]        H_COUNT,
    input  logic [9:0]        V_COUNT,
    input  logic              swap_req,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              swap_ack,
    output logic              underflow
);
    state_t             state, state_nx;
    logic [9:0]         h_q, tx, ty;
    logic [10:0]        th;
    logic               strobe, sync_hit, fetch, pop, wrap, in_win, swap;
    logic               vld_q, win_q, buf_sel, push;
    logic [MEM_LAT-1:0] sh_v, sh_w;
    logic [1:0]         prime, q_count;
    logic [7:0]         pix, push_data, q_data;
    logic               q_empty, q_full;
    always_comb begin
        strobe    = H_COUNT != h_q;
        sync_hit  = strobe && H_COUNT == 10'(H_TOTAL - 2) && V_COUNT == 10'(V_TOTAL - 1);
        fetch     = strobe && (state == RUN || sync_hit);
        pop       = fetch && prime == 2'd2;
        th        = {1'b0, H_COUNT} + 11'd2;
        wrap      = th >= 11'(H_TOTAL);
        tx        = wrap ? 10'(th - 11'(H_TOTAL)) : th[9:0];
        ty        = wrap ? (V_COUNT == 10'(V_TOTAL - 1) ? 10'd0 : V_COUNT + 10'd1) : V_COUNT;
        in_win    = tx < 10'(IMG_W) && ty < 10'(IMG_H);
        swap      = fetch && tx == 10'd0 && ty == 10'd0 && swap_req;
        push      = sh_v[MEM_LAT-1];
        push_data = sh_w[MEM_LAT-1] ? mem_data : 8'd0;
        state_nx  = (state == WAIT_SYNC && sync_hit) ? RUN : state;
    end
    always_ff @(posedge FPGA_Clock or posedge reset)
        if (reset) state <= WAIT_SYNC;
        else       state <= state_nx;
    always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) begin
            h_q       <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            vld_q     <= 1'b0;
            win_q     <= 1'b0;
            sh_v      <= '0;
            sh_w      <= '0;
            swap_ack  <= 1'b0;
            buf_sel   <= 1'b0;
            prime     <= 2'd0;
            pix       <= 8'd0;
            underflow <= 1'b0;
        end else begin
            h_q      <= H_COUNT;
            mem_rd   <= fetch && in_win;
            vld_q    <= fetch;
            win_q    <= in_win;
            // flags ride alongside the read so each push pairs with its own data beat
            sh_v     <= MEM_LAT'({sh_v, vld_q});
            sh_w     <= MEM_LAT'({sh_w, win_q});
            swap_ack <= swap;
            if (swap) buf_sel <= ~buf_sel;
            if (fetch) mem_addr <= {buf_sel ^ swap, ty[7:0], tx[7:0]};
            if (fetch && prime != 2'd2) prime <= prime + 2'd1;
            if (pop) pix <= q_count == 2'd0 ? 8'd0 : q_data;
            if ((pop && q_empty) || (push && q_full && !pop)) underflow <= 1'b1;
        end
    end
    assign R = pix;
    assign G = pix;
    assign B = pix;
    pixel_queue #(.W(8)) u_queue (
        .clk       (FPGA_Clock),
        .rst       (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (q_data),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );
endmodule
